y_fetch_pc: RTL and testbench



---
 rtl/y_fetch_pkg.sv | 13 +
 rtl/y_pc_sel.sv | 32 +++
 rtl/y_fetch_pc.sv | 117 +++++++++++
 tb/tb_y_fetch_pc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/y_fetch_pkg.sv
// y_fetch_pkg: shared types and constants for the fetch PC stage.
// Holds the fetch state enum and the instruction size.
package y_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_e;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/y_pc_sel.sv
// y_pc_sel: W-bit 2:1 next-pc select built from 1-bit muxes.
// sel=1 picks the redirect target, sel=0 the sequential pc.
module y_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

module y_pc_sel #(
  parameter int W = 32
) (
  input  logic [W-1:0] seq,
  input  logic [W-1:0] tgt,
  input  logic         sel,
  output logic [W-1:0] nxt
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    y_mux2 u_mux (
      .a (seq[i]),
      .b (tgt[i]),
      .s (sel),
      .y (nxt[i])
    );
  end

endmodule

// File: rtl/y_fetch_pc.sv
// y_fetch_pc: program counter and fetch request with branch buffering.
// Y_FETCH_ALIGN_CHK_EN: drop misaligned redirects, flag sticky misalign.
module y_fetch_pc
  import y_fetch_pkg::*;
#(
  parameter int          W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         br_en,
  input  logic [W-1:0] br_target,
  input  logic         imem_ready,
  output logic [W-1:0] pc,
  output logic         pc_valid,
  output logic [W-1:0] pc_seq,
  output logic         br_pending,
  output logic         misalign
);

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;

  logic [W-1:0] br_tgt;
  logic [W-1:0] tgt;
  logic [W-1:0] nxt;
  logic         br_ok;
  logic         sel_tgt;
  logic         xfer;

  assign br_tgt = {br_target[W-1:2], 2'b00};

`ifdef Y_FETCH_ALIGN_CHK_EN
  logic mis_q, mis_d;
  logic br_bad;

  assign br_bad   = br_en && (br_target[1:0] != 2'b00);
  assign br_ok    = br_en && !br_bad;
  assign mis_d    = mis_q || br_bad;
  assign misalign = mis_q;

  // sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`else
  logic unused_lo;

  assign unused_lo = ^br_target[1:0];
  assign br_ok     = br_en;
  assign misalign  = 1'b0;
`endif

  assign pc_valid   = (state_q == REQ);
  assign pc         = pc_q;
  assign pc_seq     = pc_q + W'(INSN_BYTES);
  assign br_pending = pend_vld_q;
  assign xfer       = pc_valid && imem_ready;
  assign sel_tgt    = pend_vld_q || br_ok;
  assign tgt        = pend_vld_q ? pend_q : br_tgt;

  y_pc_sel #(.W(W)) u_pc_sel (
    .seq (pc_seq),
    .tgt (tgt),
    .sel (sel_tgt),
    .nxt (nxt)
  );

  // next state, next pc and redirect buffering
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    unique case (state_q)
      IDLE: begin
        if (br_ok) pc_d = br_tgt;
        state_d = stall ? HOLD : REQ;
      end
      HOLD: begin
        if (br_ok) pc_d = br_tgt;
        if (!stall) state_d = REQ;
      end
      REQ: begin
        if (xfer) begin
          pc_d       = nxt;
          pend_vld_d = 1'b0;
          state_d    = stall ? HOLD : REQ;
        end else if (br_ok) begin
          pend_d     = br_tgt;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, pc and pending-target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

endmodule

// File: tb/tb_y_fetch_pc.sv
// tb_y_fetch_pc: scoreboard bench for y_fetch_pc.
// Expected transfer addresses are queued and checked on each handshake.
module tb_y_fetch_pc;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_en;
  logic [31:0] br_target;
  logic        imem_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_seq;
  logic        br_pending;
  logic        misalign;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  y_fetch_pc #(.W(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_en      (br_en),
    .br_target  (br_target),
    .imem_ready (imem_ready),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pc_seq     (pc_seq),
    .br_pending (br_pending),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every handshake must match the next queued address
  always @(negedge clk) begin
    if (rst_n && pc_valid && imem_ready) begin
      if (exp_q.size() == 0) chk("sb_extra", pc, 32'hxxxx_xxxx);
      else chk("sb_xfer_pc", pc, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    br_en = 1'b0;
    br_target = '0;
    imem_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_pend", {31'b0, br_pending}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);

    // reset exit and full-rate sequential fetch
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    rst_n = 1'b1;
    chk("exit_valid0", {31'b0, pc_valid}, 32'd0);
    cyc();
    chk("exit_valid1", {31'b0, pc_valid}, 32'd1);
    chk("seq_pc0", pc, 32'h0);
    cyc();
    chk("seq_pc4", pc, 32'h4);
    cyc();
    chk("seq_pc8", pc, 32'h8);

    // blocked at 8, redirect buffered in 2nd blocked cycle
    imem_ready = 1'b0;
    cyc();
    br_en = 1'b1;
    br_target = 32'h100;
    cyc();
    br_en = 1'b0;
    chk("blk_pc", pc, 32'h8);
    chk("blk_pend", {31'b0, br_pending}, 32'd1);
    exp_q.push_back(32'h8);
    imem_ready = 1'b1;
    cyc();
    chk("redir_pc", pc, 32'h100);
    chk("redir_pend", {31'b0, br_pending}, 32'd0);

    // two redirects while blocked, latest wins
    imem_ready = 1'b0;
    br_en = 1'b1;
    br_target = 32'h200;
    cyc();
    br_target = 32'h300;
    cyc();
    br_en = 1'b0;
    chk("two_pend", {31'b0, br_pending}, 32'd1);
    chk("two_pc_hold", pc, 32'h100);
    exp_q.push_back(32'h100);
    imem_ready = 1'b1;
    cyc();
    chk("two_pc", pc, 32'h300);

    // stall never withdraws an in-flight request
    imem_ready = 1'b0;
    stall = 1'b1;
    cyc();
    chk("stl_valid1", {31'b0, pc_valid}, 32'd1);
    chk("stl_pc1", pc, 32'h300);
    cyc();
    chk("stl_valid2", {31'b0, pc_valid}, 32'd1);
    exp_q.push_back(32'h300);
    imem_ready = 1'b1;
    cyc();
    chk("hold_valid", {31'b0, pc_valid}, 32'd0);
    chk("hold_pc", pc, 32'h304);
    cyc();
    chk("hold_valid2", {31'b0, pc_valid}, 32'd0);
    exp_q.push_back(32'h304);
    stall = 1'b0;
    cyc();
    chk("resume_valid", {31'b0, pc_valid}, 32'd1);
    chk("resume_pc", pc, 32'h304);
    cyc();
    chk("resume_pc2", pc, 32'h308);

    // redirect taken in HOLD, then wrap at top of address space
    exp_q.push_back(32'h308);
    stall = 1'b1;
    cyc();
    br_en = 1'b1;
    br_target = 32'hFFFF_FFFC;
    cyc();
    br_en = 1'b0;
    chk("hold_br_pc", pc, 32'hFFFF_FFFC);
    chk("hold_br_valid", {31'b0, pc_valid}, 32'd0);
    chk("wrap_seq0", pc_seq, 32'h0);
    stall = 1'b0;
    cyc();
    exp_q.push_back(32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_seq", pc_seq, 32'h4);

    // branch plus stall in same transfer cycle
    exp_q.push_back(32'h0);
    br_en = 1'b1;
    br_target = 32'h40;
    stall = 1'b1;
    cyc();
    br_en = 1'b0;
    stall = 1'b0;
    chk("brst_pc", pc, 32'h40);
    chk("brst_valid", {31'b0, pc_valid}, 32'd0);
    cyc();
    chk("brst_valid2", {31'b0, pc_valid}, 32'd1);

    // branch with transfer in same cycle
    exp_q.push_back(32'h40);
    br_en = 1'b1;
    br_target = 32'h80;
    cyc();
    chk("brx_pc", pc, 32'h80);

    // misaligned target
    exp_q.push_back(32'h80);
    br_target = 32'h102;
    cyc();
    br_en = 1'b0;
`ifdef Y_FETCH_ALIGN_CHK_EN
    chk("mis_pc", pc, 32'h84);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
`else
    chk("mis_pc", pc, 32'h100);
    chk("mis_flag", {31'b0, misalign}, 32'd0);
`endif

    // async reset mid-request discards pending target
    imem_ready = 1'b0;
    br_en = 1'b1;
    br_target = 32'h500;
    cyc();
    br_en = 1'b0;
    chk("prerst_pend", {31'b0, br_pending}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, pc_valid}, 32'd0);
    chk("arst_pend", {31'b0, br_pending}, 32'd0);
    chk("arst_mis", {31'b0, misalign}, 32'd0);
    cyc();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    exp_q.push_back(32'h0);
    cyc();
    chk("rexit_pc", pc, 32'h0);
    cyc();
    imem_ready = 1'b0;
    chk("rexit_pc4", pc, 32'h4);
    cyc();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
